// File: rtl/avalon_pio_pkg.sv
//------------------------------------------------------------------------------
// Module  : avalon_pio_pkg
// Brief   : Register map and edge-mode encodings for the input PIO with IRQ.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package avalon_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

`default_nettype wire

// File: rtl/pio_bit_debounce.sv
//------------------------------------------------------------------------------
// Module  : pio_bit_debounce
// Brief   : One input bit: multi-flop synchroniser followed by a stability counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pio_bit_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYC == 0) begin : g_bypass
            assign q = w_sync;
        end else begin : g_count
            localparam int         CW   = $clog2(DEBOUNCE_CYC + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

            logic [CW-1:0] r_cnt;
            logic          r_q;

            // Counter only runs while the synchronised input disagrees with the
            // accepted value, so any agreement restarts the stability window.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                    r_q   <= 1'b0;
                end else if (w_sync == r_q) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST) begin
                    r_q   <= w_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign q = r_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/avalon_input_pio_irq.sv
//------------------------------------------------------------------------------
// Module  : avalon_input_pio_irq
// Brief   : Avalon-MM input PIO with debounce, per-bit edge capture and masked IRQ.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module avalon_input_pio_irq
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int EDGE_MODE    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_next;
    logic             w_wr;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic             r_irq;
    logic [31:0]      r_readdata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pio_bit_debounce #(
                .SYNC_STAGES  (SYNC_STAGES),
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_deb (
                .clk     (clk),
                .reset_n (reset_n),
                .d       (in_port[i]),
                .q       (w_deb[i])
            );
        end

        if (WIDTH < 32) begin : g_unused_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_edge = w_deb & ~r_prev;
        if (EDGE_MODE == EDGE_FALL) begin
            w_edge = ~w_deb & r_prev;
        end else if (EDGE_MODE == EDGE_ANY) begin
            w_edge = w_deb ^ r_prev;
        end
    end

    always_comb begin
        w_rd_next = '0;
        case (address)
            ADDR_DATA:    w_rd_next[WIDTH-1:0] = w_deb;
            ADDR_IRQMASK: w_rd_next[WIDTH-1:0] = r_mask;
            ADDR_EDGECAP: w_rd_next[WIDTH-1:0] = r_cap;
            default:      w_rd_next = '0;
        endcase
    end

    // A new edge is OR-ed in after the clear so it cannot be lost to a
    // concurrent write-one-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_mask     <= '0;
            r_cap      <= '0;
            r_irq      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_prev     <= w_deb;
            r_cap      <= (r_cap & ~w_clr) | w_edge;
            r_irq      <= |(r_cap & r_mask);
            r_readdata <= w_rd_next;
            if (w_wr && address == ADDR_IRQMASK) begin
                r_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

`default_nettype wire
